ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Drives the configuration-chain protocol from the head end: bitstream words arrive over a valid/ready interface and are serialized MSB-first onto ccff_head.
- Generates the per-bit shift enable for the chain's clock gate.
- Captures the bits leaving ccff_tail (the previous chain contents) and packs them into readback words.
- Sits between the bitstream source (SPI/wishbone bridge) and the ccff_head/ccff_tail ends of the tile chain.

Parameters:
- CHAIN_LEN, 32, total configuration bits in the chain (≥1).
- WORD_W, 8, width of input and readback words (≥2).
- CNT_W, $clog2(CHAIN_LEN+1), bit-counter width (localparam, not overridable).

Ports:
- prog_clk  input  1  configuration clock; all logic on rising edge.
- pReset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; ignored while busy=1.
- abort  input  1  terminate the current load.
- cfg_data  input  WORD_W  bitstream word, MSB shifted first.
- cfg_valid  input  1  cfg_data valid.
- cfg_ready  output  1  loader accepts cfg_data this cycle.
- ccff_head  output  1  serial bit into the chain head.
- chain_clk_en  output  1  chain shift enable, for an external ICG on prog_clk.
- ccff_tail  input  1  serial bit out of the chain tail.
- rb_data  output  WORD_W  packed readback word.
- rb_valid  output  1  one-cycle strobe, rb_data valid; no backpressure.
- busy  output  1  load in progress.
- done  output  1  one-cycle strobe, full CHAIN_LEN bits shifted.

Behaviour:
- Clock and reset: one clock, prog_clk. Reset pReset is synchronous, active-high.
- Reset: state=IDLE. ccff_head=0, chain_clk_en=0, cfg_ready=0, rb_data=0, rb_valid=0, busy=0, done=0. All counters and shift registers clear. Reset mid-load drops everything, including any partial readback word; no done.
- FSM states: IDLE, FETCH, SHIFT, DONE. busy=1 in FETCH and SHIFT.
- IDLE:
  - start=1 → FETCH.
  - bit_cnt ← 0, word_idx ← 0.
- FETCH:
  - cfg_ready=1.
  - cfg_valid=1 → shreg ← cfg_data, word_idx ← 0, go to SHIFT.
- SHIFT:
  - chain_clk_en=1. ccff_head=shreg[WORD_W-1]; it is 0 in every other state.
  - Each cycle: shreg shifts left by one, bit_cnt+1, word_idx+1.
- Last bit of a word (word_idx=WORD_W-1) and bit_cnt<CHAIN_LEN-1:
  - cfg_ready=1 combinationally.
  - cfg_valid=1 → reload shreg and stay in SHIFT (no bubble).
  - cfg_valid=0 → FETCH. chain_clk_en is low for every stall cycle, so the chain holds.
- Last bit of the chain (bit_cnt=CHAIN_LEN-1): go to DONE. cfg_ready=0 on this cycle, even if it is also a word boundary.
- Partial final word: if CHAIN_LEN%WORD_W≠0, only the top CHAIN_LEN%WORD_W bits of the final word are shifted; the remaining bits are discarded.
- DONE: done=1 for one cycle, then IDLE.
- Latency: start at cycle t → cfg_ready at t+1. Word accepted at t+1 → first chain_clk_en at t+2. With no stalls, done arrives at t+2+CHAIN_LEN.
- Readback:
  - On every cycle with chain_clk_en=1, ccff_tail is sampled and shifted into rb_shreg LSB-ward; first tail bit lands in the word MSB.
  - After WORD_W captured bits: rb_data ← packed word, rb_valid=1 next cycle.
  - The final partial word is emitted on the cycle after the last shift, MSB-aligned, low bits zero. It is concurrent with done.
  - rb_data holds its value between strobes.
- Abort:
  - Valid in FETCH or SHIFT: next state IDLE. chain_clk_en=0 from the next cycle; no done; partial readback discarded; chain left partially shifted.
  - Ignored in IDLE/DONE.
  - abort and cfg_valid in the same cycle: abort wins; the word is not accepted (cfg_ready forced 0).
- start while busy: ignored; no effect on counters.

Decomposition:
- Package ccff_loader_pkg holds:
  - the state enum (IDLE, FETCH, SHIFT, DONE);
  - a helper function for the partial-word bit count (CHAIN_LEN%WORD_W, 0→WORD_W).
- Sub-module ccff_rb_packer: serial-to-parallel readback packer.
  - Inputs: sample_en, bit_in, flush, clear.
  - Outputs: rb_data, rb_valid.
  - Parameter: WORD_W.
  - Instantiated once.

Test Plan:
- Bench setup: CHAIN_LEN=32, WORD_W=8; chain model is a 32-bit shift register advancing on chain_clk_en.
- Back-to-back load: chain model preloaded 0xDEADBEEF; feed words 0x12,0x34,0x56,0x78 with cfg_valid always high → 32 contiguous chain_clk_en cycles, chain = 0x12345678 (first bit deepest), rb words 0xDE,0xAD,0xBE,0xEF, done at start+34.
- Stall: same load, cfg_valid withheld 3 cycles before word 0x56 → chain_clk_en low exactly those 3 cycles, same final chain and readback, done at start+37.
- Partial word, CHAIN_LEN=20: words 0xA5,0x3C,0xF0 → chain = 0xA53CF (20 bits); low nibble of 0xF0 unused; third rb word MSB-aligned, low 4 bits 0.
- Abort after 10 shifted bits → IDLE next cycle; no done; no third rb_valid; a following start performs a full, correct load.
- pReset asserted mid-SHIFT → next cycle all outputs at reset values; start during busy has no effect (bit count unchanged, done timing unaltered).

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bits actually shifted from the final word of a load (a full word when it divides evenly).
  function automatic int partial_bits(input int chain_len, input int word_w);
    int r;
    r = chain_len % word_w;
    return (r == 0) ? word_w : r;
  endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Serial-to-parallel packer for bits leaving the chain tail; first bit lands in the word MSB.
module ccff_rb_packer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic              bit_in,
  input  logic              flush,
  input  logic              clear,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int IDX_W = $clog2(WORD_W);

  logic [WORD_W-1:0] shreg;
  logic [IDX_W-1:0]  cnt;
  logic [WORD_W-1:0] packed_word;
  logic [IDX_W-1:0]  shamt;
  logic              word_full;

  assign packed_word = {shreg[WORD_W-2:0], bit_in};
  assign word_full   = (cnt == IDX_W'(WORD_W - 1));
  // A flushed partial word is moved up so its first bit sits in the MSB; low bits stay zero.
  assign shamt       = IDX_W'(WORD_W - 1) - cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      cnt      <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (clear) begin
        shreg <= '0;
        cnt   <= '0;
      end else if (sample_en) begin
        if (word_full || flush) begin
          rb_data  <= packed_word << shamt;
          rb_valid <= 1'b1;
          shreg    <= '0;
          cnt      <= '0;
        end else begin
          shreg <= packed_word;
          cnt   <= cnt + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Head-end driver for the configuration chain: serializes bitstream words onto ccff_head
// and packs the displaced chain contents from ccff_tail into readback words.
//
// Handshake: a word transfers on cfg_data in any cycle where cfg_valid and cfg_ready are both
// high at the rising edge of prog_clk; cfg_ready never depends on cfg_valid, and the source
// must hold cfg_data stable while cfg_valid is high without a transfer.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 32,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              chain_clk_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic [1:0]        fsm_state
);

  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int IDX_W     = $clog2(WORD_W);
  localparam int LAST_BITS = partial_bits(CHAIN_LEN, WORD_W);
  localparam bit PARTIAL   = (LAST_BITS != WORD_W);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [IDX_W-1:0]  word_idx, word_idx_nxt;
  logic [WORD_W-1:0] shreg, shreg_nxt;
  logic              last_chain, last_word, abort_hit, flush;

  assign last_chain = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign last_word  = (word_idx == IDX_W'(WORD_W - 1));
  assign fsm_state  = state;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      word_idx <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      word_idx <= word_idx_nxt;
      shreg    <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    word_idx_nxt = word_idx;
    shreg_nxt    = shreg;
    cfg_ready    = 1'b0;
    chain_clk_en = 1'b0;
    ccff_head    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    abort_hit    = 1'b0;
    flush        = 1'b0;
    case (state)
      IDLE: begin
        bit_cnt_nxt  = '0;
        word_idx_nxt = '0;
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        busy = 1'b1;
        if (abort) begin
          abort_hit = 1'b1;
          state_nxt = IDLE;
        end else begin
          cfg_ready = 1'b1;
          if (cfg_valid) begin
            shreg_nxt    = cfg_data;
            word_idx_nxt = '0;
            state_nxt    = SHIFT;
          end
        end
      end
      SHIFT: begin
        busy         = 1'b1;
        chain_clk_en = 1'b1;
        ccff_head    = shreg[WORD_W-1];
        shreg_nxt    = {shreg[WORD_W-2:0], 1'b0};
        bit_cnt_nxt  = bit_cnt + CNT_W'(1);
        word_idx_nxt = word_idx + IDX_W'(1);
        if (abort) begin
          abort_hit = 1'b1;
          state_nxt = IDLE;
        end else if (last_chain) begin
          // Unused low bits of a partial final word are simply never shifted out.
          flush     = PARTIAL;
          state_nxt = DONE;
        end else if (last_word) begin
          cfg_ready    = 1'b1;
          word_idx_nxt = '0;
          if (cfg_valid) shreg_nxt = cfg_data;
          else           state_nxt = FETCH;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  ccff_rb_packer #(.WORD_W(WORD_W)) u_rb_packer (
    .clk      (prog_clk),
    .rst      (pReset),
    .sample_en(chain_clk_en),
    .bit_in   (ccff_tail),
    .flush    (flush),
    .clear    (abort_hit),
    .rb_data  (rb_data),
    .rb_valid (rb_valid)
  );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 32-bit and a 20-bit chain, each with a shift-register chain model.
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 32-bit chain instance (a) and 20-bit chain instance (b)
  logic       start_a, abort_a, cfg_valid_a, cfg_ready_a, ccff_head_a, chain_clk_en_a;
  logic       rb_valid_a, busy_a, done_a;
  logic [7:0] cfg_data_a, rb_data_a;
  logic [1:0] fsm_state_a;
  logic       start_b, abort_b, cfg_valid_b, cfg_ready_b, ccff_head_b, chain_clk_en_b;
  logic       rb_valid_b, busy_b, done_b;
  logic [7:0] cfg_data_b, rb_data_b;
  logic [1:0] fsm_state_b;

  logic [31:0] chain_a, pre_val_a;
  logic [19:0] chain_b, pre_val_b;
  logic        pre_a = 1'b0, pre_b = 1'b0;

  ccff_chain_loader #(.CHAIN_LEN(32), .WORD_W(8)) u_dut_a (
    .prog_clk(clk), .pReset(rst), .start(start_a), .abort(abort_a),
    .cfg_data(cfg_data_a), .cfg_valid(cfg_valid_a), .cfg_ready(cfg_ready_a),
    .ccff_head(ccff_head_a), .chain_clk_en(chain_clk_en_a), .ccff_tail(chain_a[31]),
    .rb_data(rb_data_a), .rb_valid(rb_valid_a), .busy(busy_a), .done(done_a),
    .fsm_state(fsm_state_a)
  );

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut_b (
    .prog_clk(clk), .pReset(rst), .start(start_b), .abort(abort_b),
    .cfg_data(cfg_data_b), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
    .ccff_head(ccff_head_b), .chain_clk_en(chain_clk_en_b), .ccff_tail(chain_b[19]),
    .rb_data(rb_data_b), .rb_valid(rb_valid_b), .busy(busy_b), .done(done_b),
    .fsm_state(fsm_state_b)
  );

  always @(posedge clk) begin
    if (pre_a) chain_a <= pre_val_a;
    else if (chain_clk_en_a) chain_a <= {chain_a[30:0], ccff_head_a};
    if (pre_b) chain_b <= pre_val_b;
    else if (chain_clk_en_b) chain_b <= {chain_b[18:0], ccff_head_b};
  end

  // Scoreboard
  logic [7:0] exp_qa[$];
  logic [7:0] exp_qb[$];
  int compared = 0, mismatched = 0;
  int en_a = 0, gap_a = 0, done_cnt_a = 0;
  int en_b = 0, gap_b = 0, done_cnt_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chain_clk_en_a) en_a++;
    if (busy_a && !chain_clk_en_a) gap_a++;
    if (done_a) done_cnt_a++;
    if (rb_valid_a) begin
      if (exp_qa.size() == 0) chk("rb_a_unexpected", 32'(rb_data_a), 32'hFFFF_FFFF);
      else chk("rb_a", 32'(rb_data_a), 32'(exp_qa.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (chain_clk_en_b) en_b++;
    if (busy_b && !chain_clk_en_b) gap_b++;
    if (done_b) done_cnt_b++;
    if (rb_valid_b) begin
      if (exp_qb.size() == 0) chk("rb_b_unexpected", 32'(rb_data_b), 32'hFFFF_FFFF);
      else chk("rb_b", 32'(exp_qb.size() > 0 ? rb_data_b : rb_data_b), 32'(exp_qb.pop_front()));
    end
  end

  // Driver tasks; every task starts and ends 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? cfg_ready_a : cfg_ready_b;
  endfunction

  task automatic preload(input int sel, input logic [31:0] v);
    if (sel == 0) begin pre_val_a = v; pre_a = 1'b1; end
    else begin pre_val_b = v[19:0]; pre_b = 1'b1; end
    tick();
    pre_a = 1'b0;
    pre_b = 1'b0;
  endtask

  task automatic pulse_start(input int sel, output int t);
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    t = cyc;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic set_word(input int sel, input logic [7:0] d, input logic v);
    if (sel == 0) begin cfg_data_a = d; cfg_valid_a = v; end
    else begin cfg_data_b = d; cfg_valid_b = v; end
  endtask

  // Withhold the word for 'hold' cycles in which the loader was ready, then offer it.
  task automatic send_word(input int sel, input logic [7:0] d, input int hold);
    int n = 0;
    int guard = 0;
    set_word(sel, 8'h00, 1'b0);
    while (n < hold && guard < 100) begin
      @(negedge clk);
      guard++;
      if (rdy(sel)) n++;
    end
    if (hold > 0) tick();
    set_word(sel, d, 1'b1);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!rdy(sel) && guard < 100);
    if (!rdy(sel)) chk("cfg_ready_timeout", 32'(rdy(sel)), 32'd1);
    tick();
    set_word(sel, 8'h00, 1'b0);
  endtask

  task automatic wait_done(input int sel, input int exp_cyc, input string name);
    int guard = 0;
    int at = -1;
    while (at < 0 && guard < 200) begin
      @(negedge clk);
      guard++;
      if ((sel == 0) ? done_a : done_b) at = cyc;
    end
    chk(name, 32'(at), 32'(exp_cyc));
    tick();
  endtask

  task automatic check_idle(input int sel, input string name);
    if (sel == 0)
      chk(name, {17'd0, busy_a, cfg_ready_a, chain_clk_en_a, ccff_head_a, rb_valid_a,
                 done_a, fsm_state_a, rb_data_a}, 32'd0);
    else
      chk(name, {17'd0, busy_b, cfg_ready_b, chain_clk_en_b, ccff_head_b, rb_valid_b,
                 done_b, fsm_state_b, rb_data_b}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, e0, g0, d0, dummy, guard;
    rst = 1'b1;
    start_a = 0; abort_a = 0; cfg_valid_a = 0; cfg_data_a = 0;
    start_b = 0; abort_b = 0; cfg_valid_b = 0; cfg_data_b = 0;
    repeat (3) tick();
    check_idle(0, "reset_a");
    check_idle(1, "reset_b");
    rst = 1'b0;
    tick();

    // Back-to-back load
    preload(0, 32'hDEAD_BEEF);
    exp_qa.push_back(8'hDE); exp_qa.push_back(8'hAD);
    exp_qa.push_back(8'hBE); exp_qa.push_back(8'hEF);
    e0 = en_a; g0 = gap_a; d0 = done_cnt_a;
    pulse_start(0, t);
    chk("cfg_ready_after_start", 32'(cfg_ready_a), 32'd1);
    send_word(0, 8'h12, 0);
    send_word(0, 8'h34, 0);
    send_word(0, 8'h56, 0);
    send_word(0, 8'h78, 0);
    wait_done(0, t + 34, "done_b2b");
    chk("chain_b2b", chain_a, 32'h1234_5678);
    chk("shifts_b2b", 32'(en_a - e0), 32'd32);
    chk("gaps_b2b", 32'(gap_a - g0), 32'd1);
    chk("done_count_b2b", 32'(done_cnt_a - d0), 32'd1);
    chk("rbq_empty_b2b", 32'(exp_qa.size()), 32'd0);

    // Stall before the third word
    preload(0, 32'hDEAD_BEEF);
    exp_qa.push_back(8'hDE); exp_qa.push_back(8'hAD);
    exp_qa.push_back(8'hBE); exp_qa.push_back(8'hEF);
    e0 = en_a; g0 = gap_a;
    pulse_start(0, t);
    send_word(0, 8'h12, 0);
    send_word(0, 8'h34, 0);
    send_word(0, 8'h56, 3);
    send_word(0, 8'h78, 0);
    wait_done(0, t + 37, "done_stall");
    chk("chain_stall", chain_a, 32'h1234_5678);
    chk("shifts_stall", 32'(en_a - e0), 32'd32);
    chk("gaps_stall", 32'(gap_a - g0), 32'd4);
    chk("rbq_empty_stall", 32'(exp_qa.size()), 32'd0);

    // Partial final word on the 20-bit chain
    preload(1, 32'h0001_2345);
    exp_qb.push_back(8'h12); exp_qb.push_back(8'h34); exp_qb.push_back(8'h50);
    e0 = en_b;
    pulse_start(1, t);
    send_word(1, 8'hA5, 0);
    send_word(1, 8'h3C, 0);
    send_word(1, 8'hF0, 0);
    wait_done(1, t + 22, "done_partial");
    chk("chain_partial", 32'(chain_b), 32'h000A_53CF);
    chk("shifts_partial", 32'(en_b - e0), 32'd20);
    chk("rbq_empty_partial", 32'(exp_qb.size()), 32'd0);

    // Abort after 10 shifted bits; the abort cycle itself still shifts
    exp_qa.push_back(8'h12);
    e0 = en_a; d0 = done_cnt_a;
    pulse_start(0, t);
    send_word(0, 8'h9A, 0);
    send_word(0, 8'hBC, 0);
    guard = 0;
    while (en_a - e0 < 10 && guard < 100) begin tick(); guard++; end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("busy_after_abort", 32'(busy_a), 32'd0);
    chk("clk_en_after_abort", 32'(chain_clk_en_a), 32'd0);
    repeat (40) tick();
    chk("no_done_abort", 32'(done_cnt_a - d0), 32'd0);
    chk("shifts_abort", 32'(en_a - e0), 32'd11);
    chk("chain_abort", chain_a, 32'hA2B3_C4D5);
    chk("rbq_empty_abort", 32'(exp_qa.size()), 32'd0);

    // Full reload after abort, with a start pulse while busy
    exp_qa.push_back(8'hA2); exp_qa.push_back(8'hB3);
    exp_qa.push_back(8'hC4); exp_qa.push_back(8'hD5);
    e0 = en_a; d0 = done_cnt_a;
    pulse_start(0, t);
    send_word(0, 8'h12, 0);
    pulse_start(0, dummy);
    send_word(0, 8'h34, 0);
    send_word(0, 8'h56, 0);
    send_word(0, 8'h78, 0);
    wait_done(0, t + 34, "done_reload");
    chk("chain_reload", chain_a, 32'h1234_5678);
    chk("shifts_reload", 32'(en_a - e0), 32'd32);
    chk("done_count_reload", 32'(done_cnt_a - d0), 32'd1);
    chk("rbq_empty_reload", 32'(exp_qa.size()), 32'd0);

    // Reset in the middle of shifting
    e0 = en_a; d0 = done_cnt_a;
    pulse_start(0, t);
    send_word(0, 8'hFF, 0);
    guard = 0;
    while (en_a - e0 < 5 && guard < 100) begin tick(); guard++; end
    rst = 1'b1;
    tick();
    check_idle(0, "reset_mid_shift");
    rst = 1'b0;
    repeat (20) tick();
    chk("no_done_after_reset", 32'(done_cnt_a - d0), 32'd0);
    chk("rbq_empty_end", 32'(exp_qa.size() + exp_qb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
